// File: rtl/mdu_iterative_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes and op-class helpers.
package mdu_iterative_pkg;

   localparam int unsigned MduOpWidth = 3;

   // Op codes share the decoder's op field alongside the ALU op codes.
   typedef enum logic [MduOpWidth-1:0] {
      MduMult  = 3'd0,
      MduMultu = 3'd1,
      MduDiv   = 3'd2,
      MduDivu  = 3'd3,
      MduMthi  = 3'd4,
      MduMtlo  = 3'd5
   } mdu_op_e;

   function automatic logic op_is_long(input mdu_op_e op);
      return (op == MduMult) || (op == MduMultu) || (op == MduDiv) || (op == MduDivu);
   endfunction

   function automatic logic op_is_signed(input mdu_op_e op);
      return (op == MduMult) || (op == MduDiv);
   endfunction

   function automatic logic op_is_mul(input mdu_op_e op);
      return (op == MduMult) || (op == MduMultu);
   endfunction

endpackage

// File: rtl/mdu_iterative_if.sv
// Pipeline <-> MDU request/response bundle.
interface mdu_iterative_if #(
   parameter int unsigned WIDTH = 32
);
   import mdu_iterative_pkg::*;

   logic             start;
   mdu_op_e          op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cancel;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, a, b, cancel,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, a, b, cancel,
      output busy, done, hi, lo
   );

endinterface

// File: rtl/mdu_sign_fix.sv
// Conditional two's complement: passes mag through, or negates it when neg is set.
module mdu_sign_fix #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] mag,
   input  logic             neg,
   output logic [WIDTH-1:0] res
);

   // Negate on request; used both for operand abs and for result sign correction.
   always_comb begin
      res = neg ? (~mag + WIDTH'(1)) : mag;
   end

endmodule

// File: rtl/mdu_iterative.sv
// Iterative multiply/divide unit owning HI/LO. Shift-add multiply and restoring divide,
// one bit per cycle, on operand magnitudes; signs are applied in a single FIX cycle.
module mdu_iterative
   import mdu_iterative_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic           clk,
   input  logic           rst_n,
   mdu_iterative_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             is_mul_q, is_mul_d;
   logic             is_sgn_q, is_sgn_d;
   logic             sa_q, sa_d;
   logic             sb_q, sb_d;
   logic             dz_q, dz_d;
   // Multiplicand magnitude for multiply, divisor magnitude for divide.
   logic [WIDTH-1:0] opb_q, opb_d;
   // Multiply: {acc_hi, acc_lo} is the product accumulator, acc_lo starts as the multiplier.
   // Divide: acc_lo starts as the dividend and fills with quotient bits from the bottom.
   logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
   logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
   logic [WIDTH:0]   rem_q, rem_d;

   logic             a_neg, b_neg;
   logic [WIDTH-1:0] abs_a, abs_b;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH+1:0] div_shift, div_trial;
   logic             div_ge;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0] quot_fix, rem_fix;

   assign a_neg = op_is_signed(bus.op) & bus.a[WIDTH-1];
   assign b_neg = op_is_signed(bus.op) & bus.b[WIDTH-1];

   mdu_sign_fix #(.WIDTH(WIDTH)) u_abs_a (.mag(bus.a), .neg(a_neg), .res(abs_a));
   mdu_sign_fix #(.WIDTH(WIDTH)) u_abs_b (.mag(bus.b), .neg(b_neg), .res(abs_b));

   mdu_sign_fix #(.WIDTH(2 * WIDTH)) u_fix_prod (
      .mag ({acc_hi_q, acc_lo_q}),
      .neg (is_sgn_q & (sa_q ^ sb_q)),
      .res (prod_fix)
   );
   // A zero divisor keeps the all-ones quotient regardless of operand signs.
   mdu_sign_fix #(.WIDTH(WIDTH)) u_fix_quot (
      .mag (acc_lo_q),
      .neg (is_sgn_q & (sa_q ^ sb_q) & ~dz_q),
      .res (quot_fix)
   );
   mdu_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (
      .mag (rem_q[WIDTH-1:0]),
      .neg (is_sgn_q & sa_q),
      .res (rem_fix)
   );

   // Per-iteration datapath: shift-add step and restoring trial subtract.
   always_comb begin
      mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
      div_shift = {rem_q, acc_lo_q[WIDTH-1]};
      div_trial = div_shift - {2'b00, opb_q};
      div_ge    = ~div_trial[WIDTH+1];
   end

   // Next-state and datapath updates; cancel overrides everything except HI/LO retention.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      hi_d     = hi_q;
      lo_d     = lo_q;
      is_mul_d = is_mul_q;
      is_sgn_d = is_sgn_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      dz_d     = dz_q;
      opb_d    = opb_q;
      acc_hi_d = acc_hi_q;
      acc_lo_d = acc_lo_q;
      rem_d    = rem_q;

      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               if (bus.op == MduMthi) begin
                  hi_d = bus.a;
               end else if (bus.op == MduMtlo) begin
                  lo_d = bus.a;
               end else if (op_is_long(bus.op)) begin
                  state_d  = StCalc;
                  cnt_d    = '0;
                  is_mul_d = op_is_mul(bus.op);
                  is_sgn_d = op_is_signed(bus.op);
                  sa_d     = a_neg;
                  sb_d     = b_neg;
                  dz_d     = (bus.b == '0);
                  acc_hi_d = '0;
                  rem_d    = '0;
                  if (op_is_mul(bus.op)) begin
                     opb_d    = abs_a;
                     acc_lo_d = abs_b;
                  end else begin
                     opb_d    = abs_b;
                     acc_lo_d = abs_a;
                  end
               end
            end
         end
         StCalc: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (is_mul_q) begin
               {acc_hi_d, acc_lo_d} = {mul_sum, acc_lo_q[WIDTH-1:1]};
            end else begin
               acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
               rem_d    = div_ge ? div_trial[WIDTH:0] : div_shift[WIDTH:0];
            end
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = StFix;
               cnt_d   = '0;
            end
         end
         StFix: begin
            state_d = StIdle;
            done_d  = 1'b1;
            if (is_mul_q) begin
               {hi_d, lo_d} = prod_fix;
            end else begin
               hi_d = rem_fix;
               lo_d = quot_fix;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (bus.cancel) begin
         state_d = StIdle;
         cnt_d   = '0;
         done_d  = 1'b0;
         hi_d    = hi_q;
         lo_d    = lo_q;
      end
   end

   assign busy_d = (state_d != StIdle);

   // State and datapath registers, all cleared by the asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         is_mul_q <= 1'b0;
         is_sgn_q <= 1'b0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         dz_q     <= 1'b0;
         opb_q    <= '0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         rem_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         is_mul_q <= is_mul_d;
         is_sgn_q <= is_sgn_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         dz_q     <= dz_d;
         opb_q    <= opb_d;
         acc_hi_q <= acc_hi_d;
         acc_lo_q <= acc_lo_d;
         rem_q    <= rem_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

endmodule
